// File: rtl/ipbb_igr_arb_pkg.sv
// Shared types and width helpers for the ingress arbiter / packet selector pair.
package ipbb_igr_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } sel_state_e;

   localparam int DEF_NUM_QUE      = 4;
   localparam int DEF_NUM_PRIORITY = 2;
   localparam int DEF_DATA_WIDTH   = 64;

   // $clog2 that never returns 0, so single-entry fields still get one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ipbb_igr_pkt_sel.sv
// Packet selector behind the ingress priority arbiter: latches one grant, then
// streams that queue's whole packet through a registered output stage.
module ipbb_igr_pkt_sel
   import ipbb_igr_arb_pkg::*;
#(
   parameter int NUM_QUE            = DEF_NUM_QUE,
   parameter int NUM_PRIORITY       = DEF_NUM_PRIORITY,
   parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
   parameter int EMPTY_WIDTH        = clog2_min1(DATA_WIDTH / 8),
   parameter int NUM_QUE_WIDTH      = clog2_min1(NUM_QUE),
   parameter int NUM_PRIORITY_WIDTH = clog2_min1(NUM_PRIORITY)
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   // Per-queue vectors are flattened with index prio*NUM_QUE + que.
   input  logic [NUM_PRIORITY*NUM_QUE-1:0]                  i_valid,
   input  logic [NUM_PRIORITY*NUM_QUE*DATA_WIDTH-1:0]       i_data,
   input  logic [NUM_PRIORITY*NUM_QUE-1:0]                  i_sop,
   input  logic [NUM_PRIORITY*NUM_QUE-1:0]                  i_eop,
   input  logic [NUM_PRIORITY*NUM_QUE*EMPTY_WIDTH-1:0]      i_empty,
   output logic [NUM_PRIORITY*NUM_QUE-1:0]                  o_ready,
   output logic [NUM_PRIORITY*NUM_QUE-1:0]                  arb_req,
   output logic                                             arb_en,
   input  logic                                             arb_gnt_vld,
   input  logic [NUM_QUE_WIDTH-1:0]                         arb_gnt_id,
   input  logic [NUM_PRIORITY_WIDTH-1:0]                    arb_gnt_prio_id,
   output logic                                             o_valid,
   output logic                                             o_sop,
   output logic                                             o_eop,
   output logic [DATA_WIDTH-1:0]                            o_data,
   output logic [EMPTY_WIDTH-1:0]                           o_empty,
   output logic [NUM_QUE_WIDTH-1:0]                         o_que_id,
   output logic [NUM_PRIORITY_WIDTH-1:0]                    o_prio_id,
   input  logic                                             i_ready,
   output logic                                             o_err_sop
);

   localparam int NUM_SEL = NUM_PRIORITY * NUM_QUE;

   sel_state_e                    state_reg;
   logic [NUM_QUE_WIDTH-1:0]      sel_que_reg;
   logic [NUM_PRIORITY_WIDTH-1:0] sel_prio_reg;
   logic                          first_beat_reg;

   logic                          o_valid_reg;
   logic                          o_sop_reg;
   logic                          o_eop_reg;
   logic [DATA_WIDTH-1:0]         o_data_reg;
   logic [EMPTY_WIDTH-1:0]        o_empty_reg;
   logic [NUM_QUE_WIDTH-1:0]      o_que_id_reg;
   logic [NUM_PRIORITY_WIDTH-1:0] o_prio_id_reg;
   logic                          o_err_sop_reg;

   logic [NUM_SEL-1:0]            sel_hit;
   logic                          sel_valid;
   logic                          sel_sop;
   logic                          sel_eop;
   logic [DATA_WIDTH-1:0]         sel_data;
   logic [EMPTY_WIDTH-1:0]        sel_empty;
   logic                          out_ready;
   logic                          xfer_rdy;
   logic                          pop;

   // One-hot decode of the latched grant; only the selected queue may be popped.
   generate
      for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_sel
         assign sel_hit[gi] = (sel_prio_reg == NUM_PRIORITY_WIDTH'(gi / NUM_QUE)) &&
                              (sel_que_reg  == NUM_QUE_WIDTH'(gi % NUM_QUE));
         assign o_ready[gi] = sel_hit[gi] & xfer_rdy;
      end
   endgenerate

   always_comb begin
      sel_valid = |(i_valid & sel_hit);
      sel_sop   = |(i_sop & sel_hit);
      sel_eop   = |(i_eop & sel_hit);
      sel_data  = '0;
      sel_empty = '0;
      for (int i = 0; i < NUM_SEL; i++) begin
         sel_data  = sel_data  | (i_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_hit[i]}});
         sel_empty = sel_empty | (i_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH] & {EMPTY_WIDTH{sel_hit[i]}});
      end
   end

   assign out_ready = ~o_valid_reg | i_ready;
   assign xfer_rdy  = (state_reg == XFER) & out_ready;
   assign pop       = xfer_rdy & sel_valid;
   assign arb_req   = i_valid & i_sop;
   // The arbiter must not advance while this block is held in reset.
   assign arb_en    = (state_reg == IDLE) & arb_gnt_vld & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         sel_que_reg    <= '0;
         sel_prio_reg   <= '0;
         first_beat_reg <= 1'b0;
         o_valid_reg    <= 1'b0;
         o_sop_reg      <= 1'b0;
         o_eop_reg      <= 1'b0;
         o_data_reg     <= '0;
         o_empty_reg    <= '0;
         o_que_id_reg   <= '0;
         o_prio_id_reg  <= '0;
         o_err_sop_reg  <= 1'b0;
      end else begin
         o_err_sop_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (arb_gnt_vld) begin
                  sel_que_reg    <= arb_gnt_id;
                  sel_prio_reg   <= arb_gnt_prio_id;
                  first_beat_reg <= 1'b1;
                  state_reg      <= XFER;
               end
            end
            XFER: begin
               if (pop && sel_eop) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase

         if (pop) begin
            o_valid_reg    <= 1'b1;
            o_sop_reg      <= sel_sop;
            o_eop_reg      <= sel_eop;
            o_data_reg     <= sel_data;
            o_empty_reg    <= sel_empty;
            o_que_id_reg   <= sel_que_reg;
            o_prio_id_reg  <= sel_prio_reg;
            o_err_sop_reg  <= sel_sop & ~first_beat_reg;
            first_beat_reg <= 1'b0;
         end else if (i_ready) begin
            o_valid_reg <= 1'b0;
         end
      end
   end

   assign o_valid   = o_valid_reg;
   assign o_sop     = o_sop_reg;
   assign o_eop     = o_eop_reg;
   assign o_data    = o_data_reg;
   assign o_empty   = o_empty_reg;
   assign o_que_id  = o_que_id_reg;
   assign o_prio_id = o_prio_id_reg;
   assign o_err_sop = o_err_sop_reg;

endmodule
